// File: rtl/key_input_if.sv
// rtl/key_input_if.sv - key pin / core-side signal bundle for key_input
interface key_input_if;
  logic [3:0] key_n;
  logic [3:0] ack;
  logic [3:0] pressed;
  logic [3:0] press_pulse;
  logic [3:0] events;

  // Core / board side: drives pins and acknowledges, reads key state
  modport master (
    output key_n,
    output ack,
    input  pressed,
    input  press_pulse,
    input  events
  );

  // Debouncer side
  modport slave (
    input  key_n,
    input  ack,
    output pressed,
    output press_pulse,
    output events
  );
endinterface

// File: rtl/key_input.sv
// rtl/key_input.sv - four-key debouncer with press pulses, sticky events and optional auto-repeat (KEY_AUTOREPEAT_EN)
module key_input #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  key_input_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    sample;
  logic [3:0]    pressed;
  logic [3:0]    pulse;
  logic [3:0]    events;
  logic [3:0]    differ;
  logic [3:0]    accept;
  logic [3:0]    rep_fire;
  logic [CW-1:0] cnt [4];

  // Two-flop synchronizer; resets to the released (high) pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= bus.key_n;
      sync2 <= sync1;
    end
  end

  assign sample = ~sync2;

  // A level change is accepted once the differing sample has been seen for the full window
  always_comb begin
    differ = sample ^ pressed;
    accept = 4'h0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = differ[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Per-key debounce counters: any sample matching the current level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!differ[i] || accept[i]) cnt[i] <= '0;
        else                         cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold [4];
  logic [3:0]    repeating;

  // A repeat fires while the key stays held; the first interval is the delay, later ones the period
  always_comb begin
    rep_fire = 4'h0;
    for (int i = 0; i < 4; i++) begin
      rep_fire[i] = pressed[i] && !accept[i] &&
                    (hold[i] == (repeating[i] ? PERIOD_LAST : DELAY_LAST));
    end
  end

  // Hold counters run only while a key is held; release stops any further repeats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hold[i] <= '0;
      repeating <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!pressed[i] || accept[i]) begin
          hold[i]      <= '0;
          repeating[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          hold[i]      <= '0;
          repeating[i] <= 1'b1;
        end else begin
          hold[i]      <= hold[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rep_fire = 4'h0;
`endif

  // Debounced level, press strobe (registered alongside the level) and sticky events where set beats ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed <= 4'h0;
      pulse   <= 4'h0;
      events  <= 4'h0;
    end else begin
      pressed <= pressed ^ accept;
      pulse   <= (accept & sample) | rep_fire;
      events  <= (events & ~bus.ack) | pulse;
    end
  end

  assign bus.pressed     = pressed;
  assign bus.press_pulse = pulse;
  assign bus.events      = events;

endmodule

// File: doc/key_input.md
# key_input

Debounces the four active-low push-button pins and turns each key into a clean pressed level, a one-cycle press pulse and a sticky press event. The block sits between the KEY1..KEY4 board pins and the low nibble of the core's IN word. The core reads levels for held-key logic and events for edge-triggered actions. The core clears serviced events with an acknowledge strobe.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized samples required before a level change is accepted (1 ms at 50 MHz); legal range 2..2^20.
- REPEAT_DELAY, 25000000: cycles a key must stay held before the first auto-repeat pulse. Used only when auto-repeat is compiled in.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat pulses. Used only when auto-repeat is compiled in.
- CLK  input  1  system clock; all state changes on its rising edge.
- RST_N  input  1  asynchronous, active-low reset; deassertion is synchronous to CLK at top level.
- KEY_N  input  4  raw button pins, active-low, asynchronous to CLK; bit i is key i.
- ACK  input  4  per-key event clear strobe from the core, active-high, sampled each cycle.
- PRESSED  output  4  debounced level, 1 = held.
- PRESS_PULSE  output  4  one-cycle strobe per accepted press (and per repeat, if enabled).
- EVENTS  output  4  sticky press flags, set by PRESS_PULSE, cleared by ACK.

## Operation
- Synchronizer: two flip-flops per key. Reset value is 1 (released). The synchronized sample is inverted to active-high, giving S[i].
- Each key has an independent debounce counter, width ceil(log2(DEBOUNCE_CYCLES)).
  - If S[i] == PRESSED[i], the counter is cleared to 0.
  - Otherwise the counter increments.
  - When S[i] != PRESSED[i] and the counter == DEBOUNCE_CYCLES-1, PRESSED[i] toggles on that edge and the counter clears.
- Glitch rule: any sample equal to the current level restarts the count. A bounce shorter than DEBOUNCE_CYCLES never changes PRESSED.
- PRESS_PULSE[i] is 1 for exactly the cycle in which PRESSED[i] first reads 1 (registered, not combinational). A release produces no pulse.
- EVENTS[i]:
  - Set to 1 on the edge after PRESS_PULSE[i]==1.
  - Cleared on the edge after ACK[i]==1.
  - If PRESS_PULSE[i] and ACK[i] are both 1 in the same cycle, EVENTS[i] ends at 1 (set wins, so no press is lost).
  - ACK of an already-clear bit has no effect.
- All four keys operate independently; simultaneous presses produce simultaneous pulses.
- Reset (any time, including mid-debounce or mid-repeat):
  - PRESSED, PRESS_PULSE and EVENTS go to 0.
  - Counters go to 0.
  - Synchronizers go to 1.
  - A key held through reset is re-accepted after a full debounce window following release of reset.

## Timing
- Press latency: a raw falling edge on KEY_N[i] that stays stable produces PRESSED[i]=1 and PRESS_PULSE[i]=1 exactly 2 + DEBOUNCE_CYCLES rising edges later.
- Release latency: the same 2 + DEBOUNCE_CYCLES edges; no pulse is generated.
- EVENTS[i] rises one cycle after PRESS_PULSE[i].
- EVENTS[i] falls one cycle after ACK[i] when no simultaneous pulse occurs.
- Outputs change only on CLK rising edges or on RST_N assertion.

## Configuration
- KEY_AUTOREPEAT_EN defined:
  - Each key has a hold counter that starts when PRESSED[i] rises.
  - After REPEAT_DELAY cycles held, PRESS_PULSE[i] fires for one cycle. It then fires every REPEAT_PERIOD cycles while held.
  - Repeat pulses set EVENTS exactly as press pulses do.
  - Release (PRESSED[i] falling) or reset clears the hold counter immediately, and no further repeats occur.
- KEY_AUTOREPEAT_EN undefined:
  - No hold counters are built, and REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - Exactly one PRESS_PULSE occurs per accepted press.

## Test plan
Run with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: KEY_N[0] falls at edge 0 and is held → PRESSED[0]=1 and PRESS_PULSE[0]=1 at edge 6 only; EVENTS[0]=1 from edge 7; other bits stay 0.
- Bounce: KEY_N[1] toggles low/high every 2 cycles for 20 cycles, then holds high → PRESSED[1], PRESS_PULSE[1] and EVENTS[1] stay 0 throughout.
- ACK collision: drive ACK[2]=1 in the same cycle as PRESS_PULSE[2]=1 → EVENTS[2]=1 afterwards. A later lone ACK[2] → EVENTS[2]=0 the next cycle.
- Release: press key 3, then release it → PRESSED[3] returns to 0 six edges after the raw rise; no pulse on release; EVENTS[3] stays 1 until acknowledged.
- Reset mid-debounce: assert RST_N=0 two cycles into a key-0 debounce window → all outputs read 0 immediately. With the key held after reset release, PRESSED[0] rises 6 edges after RST_N deasserts.
- Auto-repeat (KEY_AUTOREPEAT_EN defined): hold key 0 for 30 cycles after acceptance → pulses at acceptance, +10, +13, +16, ... until release. Without the macro, only the acceptance pulse occurs.
